// File: rtl/adder_seq_param.sv
// Multi-cycle ripple adder/subtractor: WIDTH-bit operands, CHUNK bits per clock,
// least-significant chunk first, with a start/busy/done handshake.
module adder_seq_param #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int N  = WIDTH / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] shadow_nxt;
   logic             cy;
   logic [IW-1:0]    idx;
   logic [CHUNK-1:0] ca;
   logic [CHUNK-1:0] cb;
   logic [CHUNK:0]   part;
   logic             msb_cin;

   // Operands shift right each RUN cycle, so the active chunk is always
   // the bottom CHUNK bits; results enter the shadow from the top.
   always_comb begin
      ca         = opa[CHUNK-1:0];
      cb         = opb[CHUNK-1:0];
      part       = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, cy};
      msb_cin    = ca[CHUNK-1] ^ cb[CHUNK-1] ^ part[CHUNK-1];
      shadow_nxt = (shadow >> CHUNK)
                 | (WIDTH'(part[CHUNK-1:0]) << (WIDTH - CHUNK));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
         cy       <= 1'b0;
         idx      <= '0;
         opa      <= '0;
         opb      <= '0;
         shadow   <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  opa   <= a;
                  opb   <= sub ? ~b : b;
                  cy    <= sub | cin;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               opa    <= opa >> CHUNK;
               opb    <= opb >> CHUNK;
               cy     <= part[CHUNK];
               shadow <= shadow_nxt;
               idx    <= idx + IW'(1);
               if (idx == IW'(N - 1)) begin
                  sum      <= shadow_nxt;
                  carry    <= part[CHUNK];
                  overflow <= msb_cin ^ part[CHUNK];
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_seq_param.sv
// Bench for adder_seq_param: four parameterisations, scoreboard queues
// filled at start and drained when done pulses.
module tb_adder_seq_param;

   typedef struct {
      logic [31:0] sum;
      logic        c;
      logic        v;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   exp_t q16[$];
   exp_t q4[$];
   exp_t q8[$];
   exp_t q32[$];

   logic        st16, ci16, sb16, busy16, done16, cy16, ov16;
   logic [15:0] a16, b16, sum16;
   logic        st4, ci4, sb4, busy4, done4, cy4, ov4;
   logic [3:0]  a4, b4, sum4;
   logic        st8, ci8, sb8, busy8, done8, cy8, ov8;
   logic [7:0]  a8, b8, sum8;
   logic        st32, ci32, sb32, busy32, done32, cy32, ov32;
   logic [31:0] a32, b32, sum32;

   adder_seq_param #(.WIDTH(16), .CHUNK(4)) u16 (
      .clk(clk), .rst(rst), .start(st16), .a(a16), .b(b16),
      .cin(ci16), .sub(sb16), .busy(busy16), .done(done16),
      .sum(sum16), .carry(cy16), .overflow(ov16));

   adder_seq_param #(.WIDTH(4), .CHUNK(4)) u4 (
      .clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4),
      .cin(ci4), .sub(sb4), .busy(busy4), .done(done4),
      .sum(sum4), .carry(cy4), .overflow(ov4));

   adder_seq_param #(.WIDTH(8), .CHUNK(1)) u8 (
      .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8),
      .cin(ci8), .sub(sb8), .busy(busy8), .done(done8),
      .sum(sum8), .carry(cy8), .overflow(ov8));

   adder_seq_param #(.WIDTH(32), .CHUNK(8)) u32 (
      .clk(clk), .rst(rst), .start(st32), .a(a32), .b(b32),
      .cin(ci32), .sub(sb32), .busy(busy32), .done(done32),
      .sum(sum32), .carry(cy32), .overflow(ov32));

   // Reference: whole-word add on effective operands, signed overflow
   // from operand/result sign bits.
   function automatic exp_t model(input int w, input logic [31:0] x,
                                  input logic [31:0] y, input logic ci,
                                  input logic sb);
      exp_t        e;
      logic [32:0] m;
      logic [32:0] full;
      logic [31:0] yy;
      logic        c0;
      m      = (33'd1 << w) - 33'd1;
      yy     = sb ? ~y : y;
      c0     = sb ? 1'b1 : ci;
      full   = ({1'b0, x} & m) + ({1'b0, yy} & m) + {32'd0, c0};
      e.sum  = full[31:0] & m[31:0];
      e.c    = ((full >> w) & 33'd1) != 33'd0;
      e.v    = ((((x ^ yy) >> (w - 1)) & 32'd1) == 32'd0)
            && ((((e.sum ^ x) >> (w - 1)) & 32'd1) != 32'd0);
      return e;
   endfunction

   task automatic run16(input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tc, input logic ts, input bit hold,
                        output logic [15:0] rs, output logic rc,
                        output logic rv, output int dc, output int bc,
                        output int nc, output int both);
      @(posedge clk); #1;
      a16 = ta; b16 = tb_; ci16 = tc; sb16 = ts; st16 = 1'b1;
      q16.push_back(model(16, {16'd0, ta}, {16'd0, tb_}, tc, ts));
      dc = -1; bc = 0; nc = 0; both = 0;
      rs = '0; rc = 1'b0; rv = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (busy16) bc++;
         if (busy16 && done16) both++;
         if (done16) begin
            nc++;
            if (dc < 0) begin
               dc = c; rs = sum16; rc = cy16; rv = ov16;
            end
         end
         @(posedge clk); #1;
         if (!hold || dc >= 0) st16 = 1'b0;
         if (hold) begin
            a16  = 16'($urandom);
            b16  = 16'($urandom);
            ci16 = 1'($urandom_range(1));
            sb16 = 1'($urandom_range(1));
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({busy16, done16, sum16, cy16, ov16} !== '0) begin
         n_fail++;
         $display("FAIL reset16: busy=%b done=%b sum=%h carry=%b ovf=%b, want all 0",
                  busy16, done16, sum16, cy16, ov16);
      end
      n_chk++;
      if ({busy32, done32, sum32, cy32, ov32} !== '0) begin
         n_fail++;
         $display("FAIL reset32: busy=%b done=%b sum=%h carry=%b ovf=%b, want all 0",
                  busy32, done32, sum32, cy32, ov32);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      exp_t e; logic [15:0] s; logic c, v; int dc, bc, nc, bb;
      run16(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, s, c, v, dc, bc, nc, bb);
      e = q16.pop_front();
      n_chk++;
      if (dc !== 5) begin
         n_fail++; $display("FAIL basic_done_cycle: got %0d want 5", dc);
      end
      n_chk++;
      if (bc !== 4) begin
         n_fail++; $display("FAIL basic_busy_cycles: got %0d want 4", bc);
      end
      n_chk++;
      if (bb !== 0) begin
         n_fail++; $display("FAIL basic_busy_and_done: got %0d want 0", bb);
      end
      n_chk++;
      if ({s, c, v} !== {16'h5555, 1'b0, 1'b0} || {s, c, v} !== {e.sum[15:0], e.c, e.v}) begin
         n_fail++;
         $display("FAIL basic_result: got %h/%b/%b want %h/%b/%b",
                  s, c, v, e.sum[15:0], e.c, e.v);
      end
   endtask

   task automatic vec16(input string nm, input logic [15:0] ta,
                        input logic [15:0] tb_, input logic tc, input logic ts);
      exp_t e; logic [15:0] s; logic c, v; int dc, bc, nc, bb;
      run16(ta, tb_, tc, ts, 1'b0, s, c, v, dc, bc, nc, bb);
      e = q16.pop_front();
      n_chk++;
      if (dc !== 5 || nc !== 1) begin
         n_fail++;
         $display("FAIL %s_timing: done cycle %0d count %0d want 5 and 1", nm, dc, nc);
      end
      n_chk++;
      if ({s, c, v} !== {e.sum[15:0], e.c, e.v}) begin
         n_fail++;
         $display("FAIL %s_result: got %h/%b/%b want %h/%b/%b",
                  nm, s, c, v, e.sum[15:0], e.c, e.v);
      end
   endtask

   task automatic test_ripple();
      vec16("ripple_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      vec16("ripple_cin", 16'h0000, 16'hFFFF, 1'b1, 1'b0);
   endtask

   task automatic test_overflow();
      vec16("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
      vec16("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1);
      vec16("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b1);
   endtask

   task automatic test_hold_start();
      exp_t e; logic [15:0] s; logic c, v; int dc, bc, nc, bb;
      run16(16'hA5C3, 16'h3C5A, 1'b1, 1'b0, 1'b1, s, c, v, dc, bc, nc, bb);
      e = q16.pop_front();
      n_chk++;
      if (nc !== 1) begin
         n_fail++; $display("FAIL hold_done_count: got %0d want 1", nc);
      end
      n_chk++;
      if ({s, c, v} !== {e.sum[15:0], e.c, e.v}) begin
         n_fail++;
         $display("FAIL hold_result: got %h/%b/%b want %h/%b/%b",
                  s, c, v, e.sum[15:0], e.c, e.v);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   dcs[2];
      logic [17:0] res[2];
      int   nd = 0;
      @(posedge clk); #1;
      a16 = 16'hABCD; b16 = 16'h1111; ci16 = 1'b1; sb16 = 1'b0; st16 = 1'b1;
      q16.push_back(model(16, 32'h0000ABCD, 32'h00001111, 1'b1, 1'b0));
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (done16) begin
            if (nd < 2) begin
               dcs[nd] = c; res[nd] = {sum16, cy16, ov16};
            end
            nd++;
         end
         @(posedge clk); #1;
         if (c == 5) begin
            a16 = 16'h0F0F; b16 = 16'hF0F1; sb16 = 1'b1;
            q16.push_back(model(16, 32'h00000F0F, 32'h0000F0F1, 1'b1, 1'b1));
         end
         if (c == 6) st16 = 1'b0;
      end
      n_chk++;
      if (nd !== 2) begin
         n_fail++; $display("FAIL b2b_done_count: got %0d want 2", nd);
      end
      for (int k = 0; k < 2; k++) begin
         e = q16.pop_front();
         if (k < nd) begin
            n_chk++;
            if (dcs[k] !== 5 + 6 * k) begin
               n_fail++;
               $display("FAIL b2b_done_cycle%0d: got %0d want %0d", k, dcs[k], 5 + 6 * k);
            end
            n_chk++;
            if (res[k] !== {e.sum[15:0], e.c, e.v}) begin
               n_fail++;
               $display("FAIL b2b_result%0d: got %h want %h",
                        k, res[k], {e.sum[15:0], e.c, e.v});
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int nd = 0;
      @(posedge clk); #1;
      a16 = 16'h7777; b16 = 16'h1234; ci16 = 1'b0; sb16 = 1'b0; st16 = 1'b1;
      @(posedge clk); #1;
      st16 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({busy16, done16, sum16, cy16, ov16} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: busy=%b done=%b sum=%h carry=%b ovf=%b, want all 0",
                  busy16, done16, sum16, cy16, ov16);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done16) nd++;
      end
      n_chk++;
      if (nd !== 0) begin
         n_fail++; $display("FAIL reset_mid_no_done: got %0d pulses want 0", nd);
      end
      vec16("after_reset", 16'h7777, 16'h1234, 1'b0, 1'b0);
   endtask

   task automatic test_sweep_4();
      exp_t e; int dc = -1; logic [5:0] r = '0;
      @(posedge clk); #1;
      a4 = 4'b1011; b4 = 4'b1111; ci4 = 1'b0; sb4 = 1'b0; st4 = 1'b1;
      q4.push_back(model(4, 32'(a4), 32'(b4), ci4, sb4));
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done4 && dc < 0) begin
            dc = c; r = {sum4, cy4, ov4};
         end
         @(posedge clk); #1;
         st4 = 1'b0;
      end
      e = q4.pop_front();
      n_chk++;
      if (dc !== 2) begin
         n_fail++; $display("FAIL w4_done_cycle: got %0d want 2", dc);
      end
      n_chk++;
      if (r !== {e.sum[3:0], e.c, e.v}) begin
         n_fail++; $display("FAIL w4_result: got %b want %b", r, {e.sum[3:0], e.c, e.v});
      end
   endtask

   task automatic test_sweep_8();
      exp_t e; int dc = -1; logic [9:0] r = '0;
      @(posedge clk); #1;
      a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0; sb8 = 1'b0; st8 = 1'b1;
      q8.push_back(model(8, 32'(a8), 32'(b8), ci8, sb8));
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (done8 && dc < 0) begin
            dc = c; r = {sum8, cy8, ov8};
         end
         @(posedge clk); #1;
         st8 = 1'b0;
      end
      e = q8.pop_front();
      n_chk++;
      if (dc !== 9) begin
         n_fail++; $display("FAIL w8_done_cycle: got %0d want 9", dc);
      end
      n_chk++;
      if (r !== {e.sum[7:0], e.c, e.v}) begin
         n_fail++; $display("FAIL w8_result: got %b want %b", r, {e.sum[7:0], e.c, e.v});
      end
   endtask

   task automatic test_random_32();
      exp_t e;
      int   got = 0;
      int   guard = 0;
      @(posedge clk); #1;
      a32 = $urandom; b32 = $urandom;
      ci32 = 1'($urandom_range(1)); sb32 = 1'($urandom_range(1));
      q32.push_back(model(32, a32, b32, ci32, sb32));
      st32 = 1'b1;
      while (got < 10000 && guard < 70000) begin
         @(negedge clk);
         guard++;
         if (done32) begin
            e = q32.pop_front();
            got++;
            n_chk++;
            if ({sum32, cy32, ov32} !== {e.sum, e.c, e.v}) begin
               n_fail++;
               $display("FAIL rand32_%0d: got %h/%b/%b want %h/%b/%b",
                        got, sum32, cy32, ov32, e.sum, e.c, e.v);
            end
            if (got < 10000) begin
               a32 = $urandom; b32 = $urandom;
               ci32 = 1'($urandom_range(1)); sb32 = 1'($urandom_range(1));
               q32.push_back(model(32, a32, b32, ci32, sb32));
            end
         end
      end
      st32 = 1'b0;
      n_chk++;
      if (got != 10000) begin
         n_fail++; $display("FAIL rand32_count: got %0d results want 10000", got);
      end
   endtask

   initial begin
      rst = 1'b1;
      st16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0; sb16 = 1'b0;
      st4  = 1'b0; a4  = '0; b4  = '0; ci4  = 1'b0; sb4  = 1'b0;
      st8  = 1'b0; a8  = '0; b8  = '0; ci8  = 1'b0; sb8  = 1'b0;
      st32 = 1'b0; a32 = '0; b32 = '0; ci32 = 1'b0; sb32 = 1'b0;
      test_reset();
      test_basic();
      test_ripple();
      test_overflow();
      test_hold_start();
      test_back_to_back();
      test_reset_mid();
      test_sweep_4();
      test_sweep_8();
      test_random_32();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/adder_seq_param.md
Name: adder_seq_param

Overview:
- Parametrised multi-cycle ripple adder/subtractor with a start/busy/done handshake.
- Processes a WIDTH-bit operand pair CHUNK bits per clock, least-significant chunk first, carrying between chunks in a register.
- Next-generation arithmetic block for datapaths that need wide add/sub with small per-cycle logic.
- Produces registered sum, carry-out and signed overflow.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH.
- Derived N = WIDTH/CHUNK, the number of RUN cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in for add mode; captured on accepted start.
- sub  input  1  mode, 0 = A+B+cin, 1 = A-B (A+~B+1, cin ignored); captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- sum  output  WIDTH  result, registered.
- carry  output  1  final carry-out; in sub mode, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, carry=0, overflow=0, internal carry and chunk index = 0.
- rst has priority over everything and aborts any operation in progress; no done pulse follows.
- States:
  - IDLE: if start=1, latch a, b (inverted if sub), cin (forced to 1 if sub) and sub; go to RUN with index=0. Otherwise stay in IDLE.
  - RUN: each cycle add chunk[index] of A, B and the carry register. Write the chunk into the sum shadow register, update the carry register and increment index. On index=N-1, go to DONE.
  - DONE: for one cycle, done=1; sum, carry and overflow update to the new result at entry to this cycle. Then go to IDLE.
- Latency:
  - start is sampled at edge 0.
  - busy is high in cycles 1..N.
  - done is high in cycle N+1.
  - A new start is accepted at the earliest in cycle N+2 (IDLE).
- start is ignored in RUN and DONE. No queueing; input changes during RUN have no effect.
- Outputs sum, carry and overflow hold their last completed result until the next DONE or rst. Partial results are never visible on sum.
- Arithmetic:
  - carry = carry out of bit WIDTH-1.
  - overflow = carry into MSB XOR carry out of MSB, where the MSB is computed on effective operands.
  - All arithmetic is modulo 2^WIDTH.
- N=1 is legal: one RUN cycle, done in cycle 2.
- busy and done are never high in the same cycle.

Test Plan:
- Basic add (WIDTH=16, CHUNK=4): a=0x1234, b=0x4321, cin=0, sub=0, start at cycle 0 -> busy cycles 1-4; done cycle 5 with sum=0x5555, carry=0, overflow=0.
- Cross-chunk carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, carry=1, overflow=0. Also a=0x0000, b=0xFFFF, cin=1 -> same result.
- Signed overflow: add 0x7FFF+0x0001 -> sum=0x8000, carry=0, overflow=1. Sub 0x8000-0x0001 -> sum=0x7FFF, carry=1, overflow=1. Sub 0x0003-0x0005 with cin=1 -> sum=0xFFFE, carry=0, overflow=0 (cin ignored).
- Handshake protection:
  - Hold start=1 through RUN while changing a/b -> exactly one done per accepted start; result matches operands captured at cycle 0.
  - Back-to-back requests: second start accepted in cycle 6, done in cycle 11.
- Reset mid-operation: assert rst in RUN cycle 2 -> next cycle busy=0, done=0, sum=0, carry=0, overflow=0; no done pulse. A following start completes normally.
- Parameter sweep:
  - WIDTH=4, CHUNK=4: a=4'b1011, b=4'b1111 -> done in cycle 2, sum=4'b1010, carry=1, overflow=0.
  - WIDTH=8, CHUNK=1: a=0x80, b=0x80 -> done in cycle 9, sum=0x00, carry=1, overflow=1.
  - WIDTH=32, CHUNK=8: 10000 random add/sub vectors checked against a reference model for sum, carry and overflow.
